// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single multi-cycle main memory between the I-cache and the D-cache.
//   One requester is granted at a time. A fill issues 8 word reads (one per cycle);
//   the returned words are routed back with a word index and a done pulse. A D-cache
//   write-through is a single write cycle followed by an ack pulse. The memory read
//   latency is not known here, so words are counted as MemDataValid arrives.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   IReq, IAddr              I-cache fill request and miss address
//   DReq, DWrite, DAddr,
//   DWriteData               D-cache request (write-through or fill), address, data
//   MemDataOut, MemDataValid memory read data and valid
//   MemEnable, MemWr,
//   MemAddr, MemDataIn       memory access command
//   FillData, FillWordIdx    returned word and its index within the block
//   IFillValid, DFillValid   FillData belongs to the I / D cache
//   IFillDone, DFillDone     last word of the block delivered (one-cycle pulse)
//   DWriteAck                D write issued to memory (one-cycle pulse)
//
// state  | meaning
// IDLE   | no access in flight; requests arbitrated here only
// FILL_I | issuing/receiving an I-cache block fill
// FILL_D | issuing/receiving a D-cache block fill
// WRITE  | single D-cache write-through cycle

module mem_arbiter #(
   parameter int WORDS_PER_BLOCK = 8,
   parameter int IDX_W           = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             IReq,
   input  logic [15:0]      IAddr,
   input  logic             DReq,
   input  logic             DWrite,
   input  logic [15:0]      DAddr,
   input  logic [15:0]      DWriteData,
   input  logic [15:0]      MemDataOut,
   input  logic             MemDataValid,
   output logic             MemEnable,
   output logic             MemWr,
   output logic [15:0]      MemAddr,
   output logic [15:0]      MemDataIn,
   output logic [15:0]      FillData,
   output logic             IFillValid,
   output logic             DFillValid,
   output logic [IDX_W-1:0] FillWordIdx,
   output logic             IFillDone,
   output logic             DFillDone,
   output logic             DWriteAck
);

   typedef enum logic [1:0] {IDLE, FILL_I, FILL_D, WRITE} state_t;

   localparam logic [IDX_W:0]   ISSUE_LOAD = (IDX_W+1)'(WORDS_PER_BLOCK);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WORDS_PER_BLOCK - 1);
   localparam logic [15:0]      BASE_MASK  = ~16'(2 * WORDS_PER_BLOCK - 1);

   state_t           state_q, state_d;
   logic [15:0]      addr_q;
   logic [15:0]      data_q;
   logic [IDX_W:0]   issue_left_q;
   logic [IDX_W-1:0] recv_idx_q;
   logic             i_priority_q;
   logic             grant_i, grant_d;

   always_comb begin
      state_d     = state_q;
      grant_i     = 1'b0;
      grant_d     = 1'b0;
      MemEnable   = 1'b0;
      MemWr       = 1'b0;
      MemAddr     = 16'h0000;
      MemDataIn   = 16'h0000;
      FillData    = 16'h0000;
      IFillValid  = 1'b0;
      DFillValid  = 1'b0;
      FillWordIdx = '0;
      IFillDone   = 1'b0;
      DFillDone   = 1'b0;
      DWriteAck   = 1'b0;
      case (state_q)
         IDLE: begin
            // I wins only when D has no request or I was passed over last time.
            if (IReq && (i_priority_q || !DReq)) begin
               grant_i = 1'b1;
               state_d = FILL_I;
            end else if (DReq) begin
               grant_d = 1'b1;
               state_d = DWrite ? WRITE : FILL_D;
            end
         end
         WRITE: begin
            MemEnable = 1'b1;
            MemWr     = 1'b1;
            MemAddr   = addr_q;
            MemDataIn = data_q;
            DWriteAck = 1'b1;
            state_d   = IDLE;
         end
         FILL_I, FILL_D: begin
            if (issue_left_q != '0) begin
               MemEnable = 1'b1;
               MemAddr   = addr_q;
            end
            if (MemDataValid) begin
               FillData    = MemDataOut;
               FillWordIdx = recv_idx_q;
               if (state_q == FILL_I) IFillValid = 1'b1;
               else                   DFillValid = 1'b1;
               if (recv_idx_q == LAST_IDX) begin
                  if (state_q == FILL_I) IFillDone = 1'b1;
                  else                   DFillDone = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         addr_q       <= 16'h0000;
         data_q       <= 16'h0000;
         issue_left_q <= '0;
         recv_idx_q   <= '0;
         i_priority_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant_i) begin
            addr_q       <= IAddr & BASE_MASK;
            issue_left_q <= ISSUE_LOAD;
            recv_idx_q   <= '0;
            i_priority_q <= 1'b0;
         end else if (grant_d) begin
            if (DWrite) begin
               addr_q <= DAddr;
               data_q <= DWriteData;
            end else begin
               addr_q       <= DAddr & BASE_MASK;
               issue_left_q <= ISSUE_LOAD;
               recv_idx_q   <= '0;
            end
            if (IReq) i_priority_q <= 1'b1;
         end else if (state_q == FILL_I || state_q == FILL_D) begin
            // addr_q doubles as the issue address, stepping one word per issue.
            if (issue_left_q != '0) begin
               issue_left_q <= issue_left_q - 1'b1;
               addr_q       <= addr_q + 16'd2;
            end
            if (MemDataValid) recv_idx_q <= recv_idx_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a fixed-latency (L=4) memory model whose
//   read data is address ^ 16'h5A5A.

module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        IReq, DReq, DWrite;
   logic [15:0] IAddr, DAddr, DWriteData;
   logic [15:0] MemDataOut;
   logic        MemDataValid;
   logic        MemEnable, MemWr;
   logic [15:0] MemAddr, MemDataIn, FillData;
   logic        IFillValid, DFillValid;
   logic [2:0]  FillWordIdx;
   logic        IFillDone, DFillDone, DWriteAck;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.WORDS_PER_BLOCK(8), .IDX_W(3)) dut (
      .clk(clk), .rst(rst),
      .IReq(IReq), .IAddr(IAddr),
      .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWriteData(DWriteData),
      .MemDataOut(MemDataOut), .MemDataValid(MemDataValid),
      .MemEnable(MemEnable), .MemWr(MemWr), .MemAddr(MemAddr), .MemDataIn(MemDataIn),
      .FillData(FillData), .IFillValid(IFillValid), .DFillValid(DFillValid),
      .FillWordIdx(FillWordIdx), .IFillDone(IFillDone), .DFillDone(DFillDone),
      .DWriteAck(DWriteAck)
   );

   // Memory model: read issued in cycle t returns data in cycle t+3 (L=4).
   // Deliberately not reset by rst, so reads in flight at reset still come back.
   logic        v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
   logic [15:0] a0 = 16'h0, a1 = 16'h0, a2 = 16'h0;
   logic        stray_v = 1'b0;

   always @(posedge clk) begin
      v0 <= MemEnable & ~MemWr;
      a0 <= MemAddr;
      v1 <= v0;
      a1 <= a0;
      v2 <= v1;
      a2 <= a1;
   end

   assign MemDataValid = v2 | stray_v;
   assign MemDataOut   = stray_v ? 16'hDEAD : (v2 ? (a2 ^ 16'h5A5A) : 16'h0000);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_quiet(input string name);
      chk({name, ".ctl"}, 32'({MemEnable, MemWr, IFillValid, DFillValid,
                               IFillDone, DFillDone, DWriteAck, FillWordIdx}), 32'h0);
      chk({name, ".addr"}, 32'(MemAddr), 32'h0);
      chk({name, ".wdata"}, 32'(MemDataIn), 32'h0);
      chk({name, ".fdata"}, 32'(FillData), 32'h0);
   endtask

   // Called just after the grant edge. Cycle j of the fill: issue while j<8 at
   // base+2j, word j-3 returns for j=3..10, done with word 7 at j=10, then one
   // idle bubble. The request is dropped right after the edge ending cycle drop_j.
   task automatic do_fill(input bit is_i, input logic [15:0] base, input int drop_j,
                          input string name);
      logic [15:0] ea;
      bit          exp_v;
      for (int j = 0; j < 11; j++) begin
         @(negedge clk);
         exp_v = (j >= 3);
         chk($sformatf("%s.en%0d", name, j), 32'(MemEnable), 32'(j < 8));
         chk($sformatf("%s.wr%0d", name, j), 32'(MemWr), 32'h0);
         if (j < 8)
            chk($sformatf("%s.addr%0d", name, j), 32'(MemAddr), 32'(base + 16'(2 * j)));
         chk($sformatf("%s.iv%0d", name, j), 32'(IFillValid), 32'(is_i && exp_v));
         chk($sformatf("%s.dv%0d", name, j), 32'(DFillValid), 32'(!is_i && exp_v));
         if (exp_v) begin
            ea = base + 16'(2 * (j - 3));
            chk($sformatf("%s.idx%0d", name, j), 32'(FillWordIdx), 32'(j - 3));
            chk($sformatf("%s.data%0d", name, j), 32'(FillData), 32'(ea ^ 16'h5A5A));
         end
         chk($sformatf("%s.idone%0d", name, j), 32'(IFillDone), 32'(is_i && j == 10));
         chk($sformatf("%s.ddone%0d", name, j), 32'(DFillDone), 32'(!is_i && j == 10));
         chk($sformatf("%s.ack%0d", name, j), 32'(DWriteAck), 32'h0);
         @(posedge clk);
         if (j == drop_j) begin
            #1;
            if (is_i) IReq = 1'b0;
            else      DReq = 1'b0;
         end
      end
      @(negedge clk);
      chk_quiet({name, ".bubble"});
      @(posedge clk);
   endtask

   typedef struct {
      bit          is_i;
      bit          dwrite;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_addr;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b1, 1'b0, 16'h0046, 16'h0000, 16'h0040};
      vecs[1] = '{1'b0, 1'b1, 16'h1234, 16'hBEEF, 16'h1234};
      vecs[2] = '{1'b0, 1'b0, 16'h2A5F, 16'h0000, 16'h2A50};
      vecs[3] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hFFF0};
      vecs[4] = '{1'b0, 1'b1, 16'h0001, 16'h0000, 16'h0001};
      vecs[5] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000};

      rst = 1'b0;
      IReq = 1'b0; DReq = 1'b0; DWrite = 1'b0;
      IAddr = 16'h0; DAddr = 16'h0; DWriteData = 16'h0;
      repeat (2) @(posedge clk);
      #1 chk_quiet("reset");
      rst = 1'b1;

      // Single transactions from the table.
      for (int i = 0; i < 6; i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         @(posedge clk);
         #1;
         if (vecs[i].is_i) begin
            IReq  = 1'b1;
            IAddr = vecs[i].addr;
         end else begin
            DReq       = 1'b1;
            DWrite     = vecs[i].dwrite;
            DAddr      = vecs[i].addr;
            DWriteData = vecs[i].wdata;
         end
         @(negedge clk);
         chk_quiet({nm, ".grant"});
         @(posedge clk);
         if (vecs[i].is_i || !vecs[i].dwrite) begin
            do_fill(vecs[i].is_i, vecs[i].exp_addr, 10, nm);
         end else begin
            @(negedge clk);
            chk({nm, ".wr_ctl"}, 32'({MemEnable, MemWr, DWriteAck, IFillValid, DFillValid}),
                32'b11100);
            chk({nm, ".wr_addr"}, 32'(MemAddr), 32'(vecs[i].exp_addr));
            chk({nm, ".wr_data"}, 32'(MemDataIn), 32'(vecs[i].wdata));
            @(posedge clk);
            #1;
            DReq   = 1'b0;
            DWrite = 1'b0;
            @(negedge clk);
            chk_quiet({nm, ".after_ack"});
         end
      end

      // Simultaneous I and D fill: D first, then I despite D still requesting,
      // then the waiting D request.
      @(posedge clk);
      #1;
      IReq = 1'b1; IAddr = 16'h0104;
      DReq = 1'b1; DWrite = 1'b0; DAddr = 16'h020A;
      @(posedge clk);
      do_fill(1'b0, 16'h0200, -1, "prio_d");
      DAddr = 16'h0300;
      do_fill(1'b1, 16'h0100, 10, "prio_i");
      do_fill(1'b0, 16'h0300, 10, "prio_d2");

      // I request withdrawn after the third word: fill still completes.
      @(posedge clk);
      #1;
      IReq = 1'b1; IAddr = 16'h3338;
      @(posedge clk);
      do_fill(1'b1, 16'h3330, 5, "drop");

      // Reset during issue k=4; the late memory words must be ignored.
      @(posedge clk);
      #1;
      IReq = 1'b1; IAddr = 16'h0800;
      @(posedge clk);
      repeat (4) @(posedge clk);
      #1;
      rst  = 1'b0;
      IReq = 1'b0;
      #1 chk_quiet("rst_async");
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (i == 1) rst = 1'b1;
         @(negedge clk);
         chk_quiet($sformatf("rst_late%0d", i));
      end

      // Stray valid while idle.
      @(posedge clk);
      #1 stray_v = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_quiet($sformatf("stray%0d", i));
      end
      @(posedge clk);
      #1 stray_v = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
